// File: rtl/rx_pkg.sv
// rx_pkg: shared FSM state type, byte width and default oversampling ratio for the receiver
package rx_pkg;
  localparam int BYTE_W = 8;
  localparam int SAMPLE_RATIO_DEF = 16;
  typedef enum logic [1:0] {IDLE, DATA, STOP, PUSH} rx_state_t;
endpackage

// File: rtl/rx_if.sv
// rx_if: byte stream handshake between the receive buffer and its consumer
interface rx_if;
  import rx_pkg::*;
  logic [BYTE_W-1:0] data_out;
  logic data_valid;
  logic data_ready;
  modport master(output data_out, data_valid, input data_ready);
  modport slave(input data_out, data_valid, output data_ready);
endinterface

// File: rtl/rx_fifo.sv
// rx_fifo: power-of-two circular byte buffer; a push into a full buffer is taken only alongside a pop
module rx_fifo
  import rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [BYTE_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [BYTE_W-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rd];
  // pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_wr <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd <= w_pop ? r_rd + 1'b1 : r_rd;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  // storage needs no reset; the head is masked while empty
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/rx_controller.sv
// rx_controller: strobe-driven serial byte receiver with stop-bit check and output buffer; optional error counter under RX_ERR_COUNT_EN
module rx_controller
  import rx_pkg::*;
#(
  parameter int SAMPLE_RATIO = SAMPLE_RATIO_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic sample_clk,
  input  logic reset,
  input  logic din,
  input  logic sample_sig,
  input  logic clear_err,
  rx_if.master bus,
  output logic frame_err,
  output logic overrun,
`ifdef RX_ERR_COUNT_EN
  output logic [7:0] err_count,
`endif
  output logic busy
);
  localparam int SW = $clog2(SAMPLE_RATIO) + 1;
  rx_state_t r_state;
  logic [BYTE_W-1:0] r_shift;
  logic [2:0] r_bit;
  logic [SW-1:0] r_stop;
  logic r_frame_err, r_overrun, r_busy;
  logic w_full, w_empty, w_pop, w_push, w_drop;
  assign w_pop  = !w_empty && bus.data_ready;
  assign w_push = r_state == PUSH && (!w_full || w_pop);
  assign w_drop = r_state == PUSH && !w_push;
  assign bus.data_valid = !w_empty;
  assign frame_err = r_frame_err;
  assign overrun = r_overrun;
  assign busy = r_busy;
  rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (sample_clk),
    .rst    (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (r_shift),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (bus.data_out)
  );
  // frame FSM: assemble 8 strobed bits LSB first, then time the stop sample from the last strobe
  always_ff @(posedge sample_clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit <= '0;
      r_stop <= '0;
      r_frame_err <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: if (sample_sig) begin
          r_shift <= {{(BYTE_W-1){1'b0}}, din};
          r_bit <= 3'd1;
          r_state <= DATA;
          r_busy <= 1'b1;
        end
        DATA: if (sample_sig) begin
          r_shift[r_bit] <= din;
          r_bit <= r_bit + 3'd1;
          r_stop <= '0;
          r_state <= r_bit == 3'd7 ? STOP : DATA;
        end
        STOP: begin
          r_stop <= r_stop + 1'b1;
          if (r_stop == SW'(SAMPLE_RATIO - 1)) begin
            r_state <= din ? PUSH : IDLE;
            r_frame_err <= !din;
            r_busy <= din;
          end
        end
        PUSH: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  // sticky overrun; a drop in the same cycle beats a clear
  always_ff @(posedge sample_clk or posedge reset)
    if (reset) r_overrun <= 1'b0;
    else r_overrun <= w_drop ? 1'b1 : clear_err ? 1'b0 : r_overrun;
`ifdef RX_ERR_COUNT_EN
  logic [7:0] r_err_cnt;
  assign err_count = r_err_cnt;
  // saturating count of framing errors and dropped bytes
  always_ff @(posedge sample_clk or posedge reset)
    if (reset) r_err_cnt <= '0;
    else r_err_cnt <= clear_err ? 8'd0 : ((r_frame_err || w_drop) && r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
`endif
endmodule
